// File: rtl/cpeta_pkg.sv
// Shared definitions for the carry-predicting error-tolerant adder pipeline.
// Defaults match the classic 16-bit, split-9 adder.
package cpeta_pkg;

   localparam int N_DEF = 16;
   localparam int K_DEF = 9;
   localparam int UP_W  = N_DEF - K_DEF;
   localparam int MAX_W = 64;

   // Low-part approximation: XOR down to the first generate bit, then all ones.
   function automatic logic [MAX_W-1:0] cpeta_low(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int k);
      logic hit;
      cpeta_low = '0;
      hit = 1'b0;
      for (int i = MAX_W - 1; i >= 0; i--) begin
         if (i < k) begin
            if (a[i] & b[i]) hit = 1'b1;
            cpeta_low[i] = hit | (a[i] ^ b[i]);
         end
      end
   endfunction

endpackage

// File: rtl/cpeta_lower.sv
// Combinational K-bit approximate low part plus predicted carry into the upper part.
module cpeta_lower
   import cpeta_pkg::*;
#(
   parameter int K = 9
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   output logic [K-1:0] lo,
   output logic         c_pred
);

   logic [MAX_W-1:0] lo_wide;
   logic             unused_hi;

   assign lo_wide   = cpeta_low({{(MAX_W-K){1'b0}}, a}, {{(MAX_W-K){1'b0}}, b}, K);
   assign lo        = lo_wide[K-1:0];
   assign unused_hi = ^lo_wide[MAX_W-1:K];
   assign c_pred    = a[K-1] & b[K-1];

endmodule

// File: rtl/cpeta_pipe.sv
// Two-stage valid/ready CPETA adder with run-time exact mode.
// Define CPETA_ERR_MON_EN to build the shadow exact adder and error monitor.
module cpeta_pipe
   import cpeta_pkg::*;
#(
   parameter int N     = 16,
   parameter int K     = 9,
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             exact_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     sum,
   output logic             cout,
   input  logic             err_clr,
   output logic [ERR_W-1:0] err_count,
   output logic [N:0]       err_max
);

   localparam int UW = N - K;

   typedef struct packed {
      logic         vld;
      logic         mode;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [K-1:0] lo;
      logic         c_pred;
   } stage1_t;

   stage1_t      s1;
   logic         s2_vld;
   logic         s1_adv;
   logic [K-1:0] lo_c;
   logic         cp_c;
   logic [UW:0]  up_sum;
   logic [N:0]   full_sum;
   logic [N:0]   res;

   assign s1_adv    = !s2_vld | out_ready;
   assign in_ready  = !s1.vld | s1_adv;
   assign out_valid = s2_vld;

   cpeta_lower #(.K(K)) u_lower (
      .a      (a[K-1:0]),
      .b      (b[K-1:0]),
      .lo     (lo_c),
      .c_pred (cp_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
      end else if (in_ready) begin
         s1.vld <= in_valid;
         if (in_valid) begin
            s1.mode   <= exact_mode;
            s1.a      <= a;
            s1.b      <= b;
            s1.lo     <= lo_c;
            s1.c_pred <= cp_c;
         end
      end
   end

   assign up_sum   = {1'b0, s1.a[N-1:K]} + {1'b0, s1.b[N-1:K]} + {{UW{1'b0}}, s1.c_pred};
   assign full_sum = {1'b0, s1.a} + {1'b0, s1.b};
   assign res      = s1.mode ? full_sum : {up_sum, s1.lo};

   // Output registers only load real beats so a stalled result never changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (s1_adv) begin
         s2_vld <= s1.vld;
         if (s1.vld) {cout, sum} <= res;
      end
   end

`ifdef CPETA_ERR_MON_EN
   logic [N:0] s1_ex;
   logic [N:0] s2_ex;
   logic [N:0] approx;
   logic [N:0] diff;
   logic       xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_ex <= '0;
         s2_ex <= '0;
      end else begin
         if (in_ready && in_valid) s1_ex <= {1'b0, a} + {1'b0, b};
         if (s1_adv && s1.vld)     s2_ex <= s1_ex;
      end
   end

   assign xfer   = out_valid & out_ready;
   assign approx = {cout, sum};
   assign diff   = (approx >= s2_ex) ? (approx - s2_ex) : (s2_ex - approx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
         err_max   <= '0;
      end else if (err_clr) begin
         err_count <= '0;
         err_max   <= '0;
      end else if (xfer) begin
         if (diff != '0 && err_count != '1) err_count <= err_count + ERR_W'(1);
         if (diff > err_max) err_max <= diff;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = err_clr;
   assign err_count  = '0;
   assign err_max    = '0;
`endif

endmodule
